dnn_fc_sigmoid_engine: RTL and testbench

Parametrised fully-connected layer engine with sigmoid activation for the MNIST inference path. It computes N_OUT neurons over N_IN signed fixed-point activations plus a bias term, fetching activations, weights and the sigmoid LUT through one synchronous memory read port. It generalises the fixed 3-bit single-configuration engine in data width, layer shape, shift/saturation and LUT size. It adds abort/clear and an optional argmax classifier.

---
 rtl/dnn_fc_pkg.sv | 43 ++++
 rtl/dnn_fc_sat_lut_idx.sv | 27 ++
 rtl/dnn_fc_sigmoid_engine.sv | 179 +++++++++++++++++
 tb/tb_dnn_fc_sigmoid_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_fc_pkg.sv
// Shared types and helpers for the fully-connected sigmoid layer engine.
package dnn_fc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_A,
    FETCH_W,
    MAC,
    FETCH_B,
    BIAS,
    FETCH_LUT,
    STORE,
    DONE
  } state_t;

  localparam logic [15:0] DEF_ADDR_BASE_A   = 16'h0000;
  localparam logic [15:0] DEF_ADDR_BASE_W   = 16'h0191;
  localparam logic [15:0] DEF_ADDR_BASE_LUT = 16'h29be;

  // Wide enough for N_IN full-width products plus the bias product without overflow.
  function automatic int acc_width(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in + 1) + 1;
  endfunction

  function automatic int sat_idx(input longint v, input int w);
    longint lim;
    int     res;
    lim = longint'(1) << (w - 1);
    if (v >= lim)
      res = int'(lim - 1);
    else if (v < -lim)
      res = int'(-lim);
    else
      res = int'(v);
    return res;
  endfunction

  // LUT is stored with the most negative index at the base address.
  function automatic int lut_addr(input int base, input int idx, input int w);
    return base + idx + (1 << (w - 1));
  endfunction

endpackage

// File: rtl/dnn_fc_sat_lut_idx.sv
// Purpose: shift, saturate and offset the accumulator into a sigmoid LUT address.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows acc continuously.
module dnn_fc_sat_lut_idx
  import dnn_fc_pkg::*;
#(
  parameter int                    ACC_WIDTH     = 16,
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    LUT_IDX_WIDTH = 3,
  parameter int                    FRAC_SHIFT    = 0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT = ADDR_WIDTH'(DEF_ADDR_BASE_LUT)
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic        [ADDR_WIDTH-1:0] addr
);

  logic signed [ACC_WIDTH-1:0] shifted;
  longint                      shifted_ext;
  int                          idx;

  // Arithmetic shift floors toward minus infinity, so -3 >>> 1 lands on -2.
  assign shifted     = acc >>> FRAC_SHIFT;
  assign shifted_ext = longint'(shifted);
  assign idx         = sat_idx(shifted_ext, LUT_IDX_WIDTH);
  assign addr        = ADDR_WIDTH'(lut_addr(int'(ADDR_BASE_LUT), idx, LUT_IDX_WIDTH));

endmodule

// File: rtl/dnn_fc_sigmoid_engine.sv
// Purpose: FC layer (N_OUT x N_IN MAC + bias) with sigmoid LUT; DNN_FC_ARGMAX_EN adds a classifier.
// Latency: done rises N_OUT*(3*N_IN+4)+1 cycles after start is sampled.
// Backpressure: none; start ignored while busy or done, clr aborts to IDLE.
module dnn_fc_sigmoid_engine
  import dnn_fc_pkg::*;
#(
  parameter int                           DATA_WIDTH    = 3,
  parameter int                           ADDR_WIDTH    = 16,
  parameter int                           N_IN          = 400,
  parameter int                           N_OUT         = 10,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_A   = ADDR_WIDTH'(DEF_ADDR_BASE_A),
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_W   = ADDR_WIDTH'(DEF_ADDR_BASE_W),
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_LUT = ADDR_WIDTH'(DEF_ADDR_BASE_LUT),
  parameter int                           LUT_IDX_WIDTH = 3,
  parameter int                           FRAC_SHIFT    = 0,
  parameter logic signed [DATA_WIDTH-1:0] BIAS_ONE_VAL  = DATA_WIDTH'(2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  output logic        [ADDR_WIDTH-1:0] mem_addr,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] out [N_OUT]
`ifdef DNN_FC_ARGMAX_EN
  ,
  output logic [$clog2(N_OUT)-1:0]     class_idx,
  output logic                         class_valid
`endif
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N_IN);
  localparam int IW        = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NW        = $clog2(N_OUT);
  localparam int PW        = 2 * DATA_WIDTH;

  localparam logic [IW-1:0]         I_LAST     = IW'(N_IN - 1);
  localparam logic [NW-1:0]         N_LAST     = NW'(N_OUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(N_IN + 1);
  localparam logic [ADDR_WIDTH-1:0] BIAS_OFS   = ADDR_WIDTH'(N_IN);

  state_t                        state;
  state_t                        state_nxt;
  logic        [IW-1:0]          i_cnt;
  logic        [NW-1:0]          n_cnt;
  logic        [ADDR_WIDTH-1:0]  w_row;
  logic signed [DATA_WIDTH-1:0]  a_reg;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [DATA_WIDTH-1:0]  mul_a;
  logic signed [PW-1:0]          prod;
  logic        [ADDR_WIDTH-1:0]  lut_addr_w;

  dnn_fc_sat_lut_idx #(
    .ACC_WIDTH    (ACC_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .LUT_IDX_WIDTH(LUT_IDX_WIDTH),
    .FRAC_SHIFT   (FRAC_SHIFT),
    .ADDR_BASE_LUT(ADDR_BASE_LUT)
  ) u_sat_lut_idx (
    .acc (acc),
    .addr(lut_addr_w)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else if (clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = ADDR_BASE_A;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nxt = FETCH_A;
      end
      FETCH_A: begin
        mem_addr  = ADDR_BASE_A + ADDR_WIDTH'(i_cnt);
        state_nxt = FETCH_W;
      end
      FETCH_W: begin
        mem_addr  = w_row + ADDR_WIDTH'(i_cnt);
        state_nxt = MAC;
      end
      MAC:       state_nxt = (i_cnt == I_LAST) ? FETCH_B : FETCH_A;
      FETCH_B: begin
        mem_addr  = w_row + BIAS_OFS;
        state_nxt = BIAS;
      end
      BIAS:      state_nxt = FETCH_LUT;
      FETCH_LUT: begin
        mem_addr  = lut_addr_w;
        state_nxt = STORE;
      end
      STORE:     state_nxt = (n_cnt == N_LAST) ? DONE : FETCH_A;
      DONE:      busy = 1'b0;
      default:   state_nxt = IDLE;
    endcase
  end

  // One multiplier serves both the activation MACs and the bias term.
  assign mul_a = (state == BIAS) ? BIAS_ONE_VAL : a_reg;
  assign prod  = PW'(mul_a) * PW'(mem_data);

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_cnt <= '0;
      n_cnt <= '0;
      w_row <= ADDR_BASE_W;
      a_reg <= '0;
      acc   <= '0;
      done  <= 1'b0;
      for (int k = 0; k < N_OUT; k++)
        out[k] <= '0;
    end else if (clr) begin
      i_cnt <= '0;
      n_cnt <= '0;
      w_row <= ADDR_BASE_W;
      acc   <= '0;
      done  <= 1'b0;
    end else begin
      // done is registered, so it trails entry into DONE by one cycle.
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            i_cnt <= '0;
            n_cnt <= '0;
            w_row <= ADDR_BASE_W;
            acc   <= '0;
          end
        end
        FETCH_W: a_reg <= mem_data;
        MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          if (i_cnt != I_LAST)
            i_cnt <= i_cnt + IW'(1);
        end
        BIAS: acc <= acc + ACC_WIDTH'(prod);
        STORE: begin
          out[n_cnt] <= mem_data;
          if (n_cnt != N_LAST) begin
            n_cnt <= n_cnt + NW'(1);
            i_cnt <= '0;
            acc   <= '0;
            w_row <= w_row + ROW_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DNN_FC_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] max_val;

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      class_idx <= '0;
      max_val   <= '0;
    end else if (state == STORE && (n_cnt == '0 || mem_data > max_val)) begin
      class_idx <= n_cnt;
      max_val   <= mem_data;
    end
  end

  assign class_valid = done;
`endif

endmodule

// File: tb/tb_dnn_fc_sigmoid_engine.sv
// Randomized and directed checks of the FC sigmoid engine against an arithmetic layer model.
module tb_dnn_fc_sigmoid_engine;

  localparam int DW       = 3;
  localparam int AW       = 16;
  localparam int NI       = 2;
  localparam int NO       = 2;
  localparam int A_B      = 'h0000;
  localparam int W_B      = 'h0191;
  localparam int L_B      = 'h29be;
  localparam int BIAS_ONE = 1;
  localparam int RUN_LEN  = NO * (3 * NI + 4);
  localparam int LAT      = RUN_LEN + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, clr;
  logic signed [DW-1:0] mem_data0, mem_data1;
  logic [AW-1:0]        mem_addr0, mem_addr1;
  logic                 busy0, busy1, done0, done1;
  logic signed [DW-1:0] out0 [NO];
  logic signed [DW-1:0] out1 [NO];
`ifdef DNN_FC_ARGMAX_EN
  logic [$clog2(NO)-1:0] cls0, cls1;
  logic                  cv0, cv1;
`endif

  logic signed [DW-1:0] mem [65536];
  int n_vec = 0;
  int n_err = 0;
  int exp0 [NO];
  int exp1 [NO];

  always @(posedge clk) begin
    mem_data0 <= mem[mem_addr0];
    mem_data1 <= mem[mem_addr1];
  end

  dnn_fc_sigmoid_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_IN(NI), .N_OUT(NO),
    .ADDR_BASE_A(16'h0000), .ADDR_BASE_W(16'h0191), .ADDR_BASE_LUT(16'h29be),
    .LUT_IDX_WIDTH(3), .FRAC_SHIFT(0), .BIAS_ONE_VAL(3'sd1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .mem_data(mem_data0),
    .mem_addr(mem_addr0), .busy(busy0), .done(done0), .out(out0)
`ifdef DNN_FC_ARGMAX_EN
    , .class_idx(cls0), .class_valid(cv0)
`endif
  );

  dnn_fc_sigmoid_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_IN(NI), .N_OUT(NO),
    .ADDR_BASE_A(16'h0000), .ADDR_BASE_W(16'h0191), .ADDR_BASE_LUT(16'h29be),
    .LUT_IDX_WIDTH(3), .FRAC_SHIFT(1), .BIAS_ONE_VAL(3'sd1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .mem_data(mem_data1),
    .mem_addr(mem_addr1), .busy(busy1), .done(done1), .out(out1)
`ifdef DNN_FC_ARGMAX_EN
    , .class_idx(cls1), .class_valid(cv1)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_acc(input int n);
    int s, a, w;
    s = 0;
    for (int j = 0; j <= NI; j++) begin
      a = (j == NI) ? BIAS_ONE : int'(mem[A_B + j]);
      w = mem[W_B + n * (NI + 1) + j];
      s += a * w;
    end
    return s;
  endfunction

  function automatic int ref_idx(input int n, input int shift);
    int v;
    v = ref_acc(n);
    v = (v >= 0) ? v / (1 << shift) : -((-v + (1 << shift) - 1) / (1 << shift));
    if (v > 3)  v = 3;
    if (v < -4) v = -4;
    return v;
  endfunction

  function automatic int ref_out(input int n, input int shift);
    int v;
    v = mem[L_B + ref_idx(n, shift) + 4];
    return v;
  endfunction

  task automatic set_layer(input int a0, input int a1, input int w00, input int w01,
                           input int w02, input int w10, input int w11, input int w12);
    mem[A_B + 0] = DW'(a0);  mem[A_B + 1] = DW'(a1);
    mem[W_B + 0] = DW'(w00); mem[W_B + 1] = DW'(w01); mem[W_B + 2] = DW'(w02);
    mem[W_B + 3] = DW'(w10); mem[W_B + 4] = DW'(w11); mem[W_B + 5] = DW'(w12);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic run_layer(input string tag);
    int k;
    int exp_addr [$];
    int best0, best1;
    // -1 marks cycles whose address is unconstrained
    for (int n = 0; n < NO; n++) begin
      for (int i = 0; i < NI; i++) begin
        exp_addr.push_back(A_B + i);
        exp_addr.push_back(W_B + n * (NI + 1) + i);
        exp_addr.push_back(-1);
      end
      exp_addr.push_back(W_B + n * (NI + 1) + NI);
      exp_addr.push_back(-1);
      exp_addr.push_back(L_B + ref_idx(n, 0) + 4);
      exp_addr.push_back(-1);
    end
    exp_addr.push_back(A_B);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!done0 && k < 200) begin
      if (k < exp_addr.size() && exp_addr[k] >= 0)
        check({tag, " addr"}, int'(mem_addr0), exp_addr[k]);
      check({tag, " busy"}, int'(busy0), (k < RUN_LEN) ? 1 : 0);
      tick();
      k++;
    end
    check({tag, " latency"}, k, LAT);
    check({tag, " done1"}, int'(done1), 1);
    for (int n = 0; n < NO; n++) begin
      exp0[n] = ref_out(n, 0);
      exp1[n] = ref_out(n, 1);
      check({tag, $sformatf(" out0[%0d]", n)}, int'(out0[n]), exp0[n]);
      check({tag, $sformatf(" out1[%0d]", n)}, int'(out1[n]), exp1[n]);
    end
    best0 = 0;
    best1 = 0;
    for (int n = 1; n < NO; n++) begin
      if (exp0[n] > exp0[best0]) best0 = n;
      if (exp1[n] > exp1[best1]) best1 = n;
    end
`ifdef DNN_FC_ARGMAX_EN
    check({tag, " class_idx0"}, int'(cls0), best0);
    check({tag, " class_idx1"}, int'(cls1), best1);
    check({tag, " class_valid"}, int'(cv0), int'(done0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    for (int k = 0; k < 8; k++) mem[L_B + k] = DW'(k - 4);
    set_layer(1, 2, 1, 1, 0, -1, -2, -1);
    repeat (3) tick();

    check("reset done", int'(done0), 0);
    check("reset busy", int'(busy0), 0);
    check("reset out0", int'(out0[0]), 0);
    check("reset out1", int'(out0[1]), 0);
    check("reset addr", int'(mem_addr0), A_B);
    rst = 1'b1;
    tick();

    run_layer("basic");
    check("basic const out[0]", int'(out0[0]), 3);
    check("basic const out[1]", int'(out0[1]), -4);
    check("basic shift1 out[0]", int'(out1[0]), 1);
    check("basic shift1 out[1]", int'(out1[1]), -3);

    // start held in DONE must not restart fetching
    start = 1'b1;
    repeat (4) begin
      tick();
      check("done hold addr", int'(mem_addr0), A_B);
      check("done hold busy", int'(busy0), 0);
      check("done hold done", int'(done0), 1);
    end
    start = 1'b0;
    pulse_clr();
    check("clr done", int'(done0), 0);
    check("clr busy", int'(busy0), 0);
    check("clr keeps out[0]", int'(out0[0]), exp0[0]);
    run_layer("rerun");

    // reset in the middle of a run
    pulse_clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst done", int'(done0), 0);
    check("midrst busy", int'(busy0), 0);
    check("midrst out[0]", int'(out0[0]), 0);
    check("midrst out[1]", int'(out0[1]), 0);
    check("midrst addr", int'(mem_addr0), A_B);
    run_layer("after reset");

    // abort with clr, then clr+start together
    pulse_clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    pulse_clr();
    check("abort busy", int'(busy0), 0);
    check("abort done", int'(done0), 0);
    check("abort addr", int'(mem_addr0), A_B);
    check("abort keeps out[0]", int'(out0[0]), exp0[0]);
    check("abort keeps out[1]", int'(out0[1]), exp0[1]);
    clr   = 1'b1;
    start = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    check("clr+start busy", int'(busy0), 0);
    tick();
    check("clr+start idle", int'(busy0), 0);
    run_layer("after abort");

    // saturation and negative floor with shift
    pulse_clr();
    set_layer(1, 2, 3, 3, 3, -1, -1, 0);
    run_layer("shift");
    check("shift sat out1[0]", int'(out1[0]), 3);
    check("shift floor out1[1]", int'(out1[1]), -2);

    // equal outputs for both neurons
    pulse_clr();
    set_layer(1, 2, 1, 1, 0, 1, 1, 0);
    run_layer("tie");

    for (int r = 0; r < 8; r++) begin
      pulse_clr();
      for (int j = 0; j < NI; j++) mem[A_B + j] = DW'($urandom_range(7));
      for (int j = 0; j < NO * (NI + 1); j++) mem[W_B + j] = DW'($urandom_range(7));
      for (int j = 0; j < 8; j++) mem[L_B + j] = DW'($urandom_range(7));
      run_layer($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
